// File: rtl/bus_target_pkg.sv
// Shared definitions for the rq/ack client bus: responder FSM encoding and
// the index-width helper also used by the arbiter and client blocks.
package bus_target_pkg;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_WAIT    = 2'd1,
        S_ACK     = 2'd2,
        S_RELEASE = 2'd3
    } state_e;

    // Bits needed to index `depth` entries; never less than one bit.
    function automatic int idx_width(input int depth);
        int w;
        w = 1;
        while ((1 << w) < depth) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/bus_target_regfile.sv
// Single-port storage for one bus target: synchronous write, registered read,
// and a read-data clear so the bus sees zero outside read acknowledges.
module bus_target_regfile #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 4,
    parameter int IDX_W      = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  we_i,
    input  logic                  re_i,
    input  logic                  clr_i,
    input  logic [IDX_W-1:0]      idx_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    output logic [DATA_WIDTH-1:0] rdata_o
);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            rdata_q <= '0;
        end else begin
            if (we_i) begin
                mem_q[idx_i] <= wdata_i;
            end
            if (re_i) begin
                rdata_q <= mem_q[idx_i];
            end else if (clr_i) begin
                rdata_q <= '0;
            end
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/bus_target.sv
// Target end of the rq/ack client bus: decodes its address window and
// services one read or write per request with a 4-phase ack handshake.
//
//   state     | meaning
//   ----------+------------------------------------------------------------
//   S_IDLE    | waiting for an in-window request
//   S_WAIT    | delay counter running down; rq low here aborts
//   S_ACK     | access done on entry, ack held until rq drops
//   S_RELEASE | one dead cycle so ack is low between transactions
module bus_target
    import bus_target_pkg::*;
#(
    parameter int DATA_WIDTH           = 8,
    parameter int ADDR_WIDTH           = 4,
    parameter int ADDR_SPACE_BEGINNING = 0,
    parameter int ADDR_SPACE_END       = 3,
    parameter int ACK_DELAY            = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] address,
    input  logic                  rq,
    input  logic                  wr_ni,
    input  logic [DATA_WIDTH-1:0] dataW,
    output logic                  ack,
    output logic [DATA_WIDTH-1:0] dataR
);

    localparam int DEPTH   = ADDR_SPACE_END - ADDR_SPACE_BEGINNING + 1;
    localparam int IDX_W   = idx_width(DEPTH);
    // A zero delay still spends one cycle in WAIT, so ack never rises on the
    // same edge that first samples rq.
    localparam int DLY_EFF = (ACK_DELAY < 1) ? 1 : ACK_DELAY;
    localparam int CNT_W   = idx_width(DLY_EFF + 1);

    localparam logic [ADDR_WIDTH-1:0] ADDR_LO = ADDR_WIDTH'(ADDR_SPACE_BEGINNING);
    localparam logic [ADDR_WIDTH-1:0] ADDR_HI = ADDR_WIDTH'(ADDR_SPACE_END);
    localparam logic [CNT_W-1:0]      CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0]      CNT_LD  = CNT_W'(DLY_EFF);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               ack_q, ack_d;

    logic [ADDR_WIDTH:0] off_lo, off_hi;
    logic                in_range;
    logic [IDX_W-1:0]    idx;
    logic                unused_off;

    logic mem_we, mem_re, rd_clr;

    // Window decode via borrow bits, so no comparison folds to a constant
    // when the window starts at 0 or ends at the top of the address space.
    assign off_lo     = {1'b0, address} - {1'b0, ADDR_LO};
    assign off_hi     = {1'b0, ADDR_HI} - {1'b0, address};
    assign in_range   = !off_lo[ADDR_WIDTH] && !off_hi[ADDR_WIDTH];
    assign idx        = off_lo[IDX_W-1:0];
    assign unused_off = ^{off_lo, off_hi};

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            ack_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ack_q   <= ack_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ack_d   = 1'b0;
        mem_we  = 1'b0;
        mem_re  = 1'b0;
        rd_clr  = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (rq && in_range) begin
                    cnt_d   = CNT_LD;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (!rq) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                    if (cnt_q <= CNT_ONE) begin
                        state_d = S_ACK;
                        ack_d   = 1'b1;
                        mem_we  = wr_ni;
                        mem_re  = !wr_ni;
                    end
                end
            end
            S_ACK: begin
                if (rq) begin
                    ack_d = 1'b1;
                end else begin
                    state_d = S_RELEASE;
                    rd_clr  = 1'b1;
                end
            end
            S_RELEASE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    bus_target_regfile #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .IDX_W      (IDX_W)
    ) u_regfile (
        .clk_i   (clk),
        .rst_ni  (reset),
        .we_i    (mem_we),
        .re_i    (mem_re),
        .clr_i   (rd_clr),
        .idx_i   (idx),
        .wdata_i (dataW),
        .rdata_o (dataR)
    );

    assign ack = ack_q;

endmodule

// File: tb/tb_bus_target.sv
// Directed bench for bus_target: default window 0..3 (delay 2) and a second
// instance with window 4..7 and zero delay, sharing address/data/reset.
module tb_bus_target;

    logic       clk;
    logic       reset;
    logic [3:0] address;
    logic       wr_ni;
    logic [7:0] dataW;
    logic       rq_a, rq_v;
    logic       ack_a, ack_v;
    logic [7:0] dataR_a, dataR_v;

    int total = 0;
    int bad   = 0;

    bus_target dut_a (
        .clk     (clk),
        .reset   (reset),
        .address (address),
        .rq      (rq_a),
        .wr_ni   (wr_ni),
        .dataW   (dataW),
        .ack     (ack_a),
        .dataR   (dataR_a)
    );

    bus_target #(
        .DATA_WIDTH           (8),
        .ADDR_WIDTH           (4),
        .ADDR_SPACE_BEGINNING (4),
        .ADDR_SPACE_END       (7),
        .ACK_DELAY            (0)
    ) dut_v (
        .clk     (clk),
        .reset   (reset),
        .address (address),
        .rq      (rq_v),
        .wr_ni   (wr_ni),
        .dataW   (dataW),
        .ack     (ack_v),
        .dataR   (dataR_v)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Request fields must hold while rq stays high.
    logic [3:0] addr_p;
    logic       wr_p;
    logic [7:0] dw_p;
    logic       rq_p;
    always @(posedge clk) begin
        if (reset && (rq_a || rq_v) && rq_p) begin
            assert (address == addr_p && wr_ni == wr_p && dataW == dw_p)
                else $error("protocol violation: request fields changed while rq high");
        end
        rq_p   <= rq_a || rq_v;
        addr_p <= address;
        wr_p   <= wr_ni;
        dw_p   <= dataW;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic set_rq(input bit use_v, input logic v);
        if (use_v) rq_v = v;
        else       rq_a = v;
    endtask

    function automatic logic cur_ack(input bit use_v);
        return use_v ? ack_v : ack_a;
    endfunction

    function automatic logic [7:0] cur_dat(input bit use_v);
        return use_v ? dataR_v : dataR_a;
    endfunction

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
        end
    endtask

    // Full handshake; lat = edges after the first edge that sees rq high.
    task automatic xfer(input bit use_v, input logic wr, input logic [3:0] a,
                        input logic [7:0] d, input int exp_lat,
                        input logic [7:0] exp_rd, input string tag);
        int   k;
        logic got;
        address = a;
        wr_ni   = wr;
        dataW   = d;
        set_rq(use_v, 1'b1);
        k   = 0;
        got = 1'b0;
        while (k < 20 && !got) begin
            @(posedge clk); #1;
            k++;
            got = cur_ack(use_v);
        end
        check_eq({tag, "_ack"}, 32'(got), 32'd1);
        check_eq({tag, "_lat"}, 32'(k - 1), 32'(exp_lat));
        check_eq({tag, "_data"}, 32'(cur_dat(use_v)), wr ? 32'h0 : 32'(exp_rd));
        @(posedge clk); #1;
        check_eq({tag, "_hold"}, 32'(cur_ack(use_v)), 32'd1);
        set_rq(use_v, 1'b0);
        @(posedge clk); #1;
        check_eq({tag, "_drop"}, 32'(cur_ack(use_v)), 32'd0);
        check_eq({tag, "_clr"}, 32'(cur_dat(use_v)), 32'h0);
    endtask

    // Request that must never be acknowledged (out of window or aborted).
    task automatic no_ack(input bit use_v, input logic wr, input logic [3:0] a,
                          input logic [7:0] d, input int hold, input string tag);
        logic seen;
        seen    = 1'b0;
        address = a;
        wr_ni   = wr;
        dataW   = d;
        set_rq(use_v, 1'b1);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            seen = seen | cur_ack(use_v);
        end
        set_rq(use_v, 1'b0);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            seen = seen | cur_ack(use_v);
        end
        check_eq(tag, 32'(seen), 32'd0);
    endtask

    initial begin
        int   k;
        logic got;

        reset   = 1'b0;
        rq_a    = 1'b0;
        rq_v    = 1'b0;
        address = '0;
        wr_ni   = 1'b0;
        dataW   = '0;

        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_ack_a", 32'(ack_a), 32'd0);
        check_eq("rst_dat_a", 32'(dataR_a), 32'h0);
        check_eq("rst_ack_v", 32'(ack_v), 32'd0);
        check_eq("rst_dat_v", 32'(dataR_v), 32'h0);
        reset = 1'b1;
        idle_cycles(1);

        // Out of window write, then every word still reads zero
        no_ack(1'b0, 1'b1, 4'd7, 8'h3C, 10, "oor7");
        for (int i = 0; i < 4; i++) begin
            xfer(1'b0, 1'b0, 4'(i), 8'h00, 2, 8'h00, $sformatf("oor_rd%0d", i));
            idle_cycles(1);
        end

        // Write then read with default delay
        xfer(1'b0, 1'b1, 4'd2, 8'hA5, 2, 8'h00, "t1_wr");
        idle_cycles(1);
        xfer(1'b0, 1'b0, 4'd2, 8'h00, 2, 8'hA5, "t1_rd");
        idle_cycles(1);

        // Abort in WAIT leaves storage untouched
        no_ack(1'b0, 1'b1, 4'd1, 8'hFF, 1, "t3_abort");
        xfer(1'b0, 1'b0, 4'd1, 8'h00, 2, 8'h00, "t3_rd");
        idle_cycles(1);

        // Back-to-back: rq raised during RELEASE costs one extra edge
        for (int i = 0; i < 4; i++) begin
            xfer(1'b0, 1'b1, 4'(i), 8'((i + 1) * 17), (i == 0) ? 2 : 3, 8'h00,
                 $sformatf("t4_wr%0d", i));
        end
        for (int i = 0; i < 4; i++) begin
            xfer(1'b0, 1'b0, 4'(i), 8'h00, 3, 8'((i + 1) * 17), $sformatf("t4_rd%0d", i));
        end
        idle_cycles(1);

        // Reset while ack is high
        address = 4'd3;
        wr_ni   = 1'b1;
        dataW   = 8'h5A;
        rq_a    = 1'b1;
        k   = 0;
        got = 1'b0;
        while (k < 20 && !got) begin
            @(posedge clk); #1;
            k++;
            got = ack_a;
        end
        check_eq("t5_ack_up", 32'(got), 32'd1);
        reset = 1'b0;
        rq_a  = 1'b0;
        @(posedge clk); #1;
        check_eq("t5_ack_rst", 32'(ack_a), 32'd0);
        check_eq("t5_dat_rst", 32'(dataR_a), 32'h0);
        @(posedge clk); #1;
        reset = 1'b1;
        idle_cycles(1);
        xfer(1'b0, 1'b0, 4'd3, 8'h00, 2, 8'h00, "t5_rd3");
        idle_cycles(1);
        xfer(1'b0, 1'b0, 4'd0, 8'h00, 2, 8'h00, "t5_rd0");
        idle_cycles(1);

        // Window 4..7, zero delay
        xfer(1'b1, 1'b0, 4'd4, 8'h00, 1, 8'h00, "t6_rd4");
        idle_cycles(1);
        xfer(1'b1, 1'b1, 4'd5, 8'h77, 1, 8'h00, "t6_wr5");
        idle_cycles(1);
        xfer(1'b1, 1'b0, 4'd5, 8'h00, 1, 8'h77, "t6_rd5");
        idle_cycles(1);
        no_ack(1'b1, 1'b1, 4'd3, 8'hAA, 5, "t6_oor3");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
